// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand register A, saturating down-counter B
// and a double-width accumulator P, all driven by an external controller's strobes.
module mul_datapath #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               LdA,
    input  logic               LdB,
    input  logic               LdP,
    input  logic               clrP,
    input  logic               decB,
    output logic               eqz,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   b_count
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               b_zero;

    assign b_zero = (b_q == '0);

    always_comb begin
        a_d = a_q;
        if (LdA) a_d = data_in;
    end

    // LdB wins over decB; the counter parks at zero instead of wrapping.
    always_comb begin
        b_d = b_q;
        if (LdB)                 b_d = data_in;
        else if (decB && !b_zero) b_d = b_q - WIDTH'(1);
    end

    // Accumulation is gated on B != 0 so extra LdP cycles after the count ends are harmless.
    always_comb begin
        p_d = p_q;
        if (clrP)               p_d = '0;
        else if (LdP && !b_zero) p_d = p_q + {{WIDTH{1'b0}}, a_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    assign eqz     = b_zero;
    assign product = p_q;
    assign b_count = b_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_mul_datapath;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst, LdA, LdB, LdP, clrP, decB;
    logic [W-1:0]   data_in;
    logic           eqz;
    logic [2*W-1:0] product;
    logic [W-1:0]   b_count;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    longint mA = 0, mB = 0, mP = 0;

    mul_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .eqz(eqz), .product(product), .b_count(b_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [W-1:0]   d;
        logic           lda, ldb, ldp, clrp, decb;
        logic [2*W-1:0] ep;
        logic [W-1:0]   eb;
        logic           ez;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, int d, logic la, logic lb, logic lp, logic cp,
                                logic db, longint ep, int eb, logic ez);
        vec_t v;
        v.rst = r; v.d = d[W-1:0]; v.lda = la; v.ldb = lb; v.ldp = lp;
        v.clrp = cp; v.decb = db; v.ep = ep[2*W-1:0]; v.eb = eb[W-1:0]; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle of strobes, advance the model by the rules, sample after the edge.
    task automatic apply(input logic r, input logic [W-1:0] d, input logic la, input logic lb,
                         input logic lp, input logic cp, input logic db);
        longint nA, nB, nP;
        rst = r; data_in = d; LdA = la; LdB = lb; LdP = lp; clrP = cp; decB = db;
        if (r) begin
            nA = 0; nB = 0; nP = 0;
        end else begin
            nA = la ? longint'(d) : mA;
            if (lb)                 nB = longint'(d);
            else if (db && mB > 0)  nB = mB - 1;
            else                    nB = mB;
            if (cp)                 nP = 0;
            else if (lp && mB != 0) nP = mP + mA;
            else                    nP = mP;
        end
        mA = nA; mB = nB; mP = nP;
        @(posedge clk);
        #1;
        rst = 0; LdA = 0; LdB = 0; LdP = 0; clrP = 0; decB = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " product"}, longint'(product), mP);
        chk({tag, " b_count"}, longint'(b_count), mB);
        chk({tag, " eqz"},     longint'(eqz),     longint'(mB == 0));
    endtask

    // Run accumulate cycles until eqz, bounded; returns number of steps taken.
    task automatic run_to_eqz(input int budget, output int steps);
        steps = 0;
        while (!eqz && steps < budget) begin
            apply(0, '0, 0, 0, 1, 0, 1);
            steps++;
        end
    endtask

    initial begin
        int steps;
        logic [W-1:0] ra, rb;
        rst = 1; data_in = '0; LdA = 0; LdB = 0; LdP = 0; clrP = 0; decB = 0;
        #2;

        // Directed table: state carries from row to row.
        tbl.push_back(mk(1, 0,    0,0,0,0,0,  0, 0, 1));  // reset
        tbl.push_back(mk(0, 17,   1,0,0,0,0,  0, 0, 1));  // LdA 17
        tbl.push_back(mk(0, 5,    0,1,0,1,0,  0, 5, 0));  // LdB 5 + clrP
        tbl.push_back(mk(0, 0,    0,0,1,0,1, 17, 4, 0));
        tbl.push_back(mk(0, 0,    0,0,1,0,1, 34, 3, 0));
        tbl.push_back(mk(0, 0,    0,0,1,0,1, 51, 2, 0));
        tbl.push_back(mk(0, 0,    0,0,1,0,1, 68, 1, 0));
        tbl.push_back(mk(0, 0,    0,0,1,0,1, 85, 0, 1));  // 17*5 done
        tbl.push_back(mk(0, 20,   1,0,0,0,0, 85, 0, 1));  // LdA leaves P alone
        tbl.push_back(mk(0, 2,    0,1,0,1,0,  0, 2, 0));
        tbl.push_back(mk(0, 0,    0,0,1,0,0, 20, 2, 0));  // LdP without decB
        tbl.push_back(mk(0, 0,    0,0,1,0,0, 40, 2, 0));
        tbl.push_back(mk(0, 0,    0,0,1,1,0,  0, 2, 0));  // clrP beats LdP
        tbl.push_back(mk(0, 9,    0,1,0,0,1,  0, 9, 0));  // LdB beats decB
        tbl.push_back(mk(0, 1234, 1,0,0,0,0,  0, 9, 0));
        tbl.push_back(mk(0, 0,    0,1,0,0,0,  0, 0, 1));  // zero operand
        tbl.push_back(mk(0, 0,    0,0,0,1,0,  0, 0, 1));
        tbl.push_back(mk(0, 0,    0,0,1,0,1,  0, 0, 1));
        tbl.push_back(mk(0, 0,    0,0,1,0,1,  0, 0, 1));
        tbl.push_back(mk(0, 0,    0,0,1,0,1,  0, 0, 1));
        tbl.push_back(mk(0, 3,    1,1,0,1,0,  0, 3, 0));  // LdA+LdB share data_in
        tbl.push_back(mk(0, 0,    0,0,1,0,1,  3, 2, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].d, tbl[i].lda, tbl[i].ldb, tbl[i].ldp,
                  tbl[i].clrp, tbl[i].decb);
            chk($sformatf("vec%0d product", i), longint'(product), longint'(tbl[i].ep));
            chk($sformatf("vec%0d b_count", i), longint'(b_count), longint'(tbl[i].eb));
            chk($sformatf("vec%0d eqz", i),     longint'(eqz),     longint'(tbl[i].ez));
        end

        // Maximum operands: eqz must stay low for exactly 65535 accumulate steps.
        apply(0, 16'hFFFF, 1, 0, 0, 0, 0);
        apply(0, 16'hFFFF, 0, 1, 0, 1, 0);
        chk("max eqz low at start", longint'(eqz), 0);
        run_to_eqz(70000, steps);
        chk("max steps", steps, 65535);
        chk("max product", longint'(product), 64'hFFFE0001);
        chk("max eqz end", longint'(eqz), 1);

        // Reset mid-operation, then a clean 3x4.
        apply(0, 17, 1, 0, 0, 0, 0);
        apply(0, 5,  0, 1, 0, 1, 0);
        apply(0, 0,  0, 0, 1, 0, 1);
        apply(0, 0,  0, 0, 1, 0, 1);
        chk("midrst partial", longint'(product), 34);
        apply(1, 16'h5A5A, 1, 1, 1, 0, 1);
        chk("midrst product", longint'(product), 0);
        chk("midrst b_count", longint'(b_count), 0);
        chk("midrst eqz",     longint'(eqz), 1);
        chk("midrst A cleared", mA, 0);
        apply(0, 3, 1, 0, 0, 0, 0);
        apply(0, 4, 0, 1, 0, 1, 0);
        run_to_eqz(10, steps);
        chk("after rst 3x4", longint'(product), 12);

        // Overrun: extra accumulate cycles after completion do nothing.
        apply(0, 7, 1, 0, 0, 0, 0);
        apply(0, 3, 0, 1, 0, 1, 0);
        run_to_eqz(10, steps);
        chk("overrun done", longint'(product), 21);
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1, 0, 1);
        chk("overrun product", longint'(product), 21);
        chk("overrun b_count", longint'(b_count), 0);

        // Random full multiplies checked against plain arithmetic.
        for (int t = 0; t < 20; t++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 40));
            apply(0, ra, 1, 0, 0, 0, 0);
            apply(0, rb, 0, 1, 0, 1, 0);
            run_to_eqz(100, steps);
            chk($sformatf("rand mul %0dx%0d", ra, rb), longint'(product),
                longint'(ra) * longint'(rb));
            chk($sformatf("rand steps %0d", t), steps, int'(rb));
        end

        // Random strobe soup against the model.
        for (int t = 0; t < 200; t++) begin
            apply(($urandom_range(0, 31) == 0), W'($urandom_range(0, 12)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 0));
            chk_model($sformatf("soup%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
